// File: rtl/spi_cmd_master.sv
// spi_cmd_master: 32-bit command-frame SPI controller, SPI mode 0.
// Frame: {rw_b, addr[16], 6'b0}, addr[15:8], addr[7:0], data (8'h00 for reads).
// Build option: define SPI_CMD_MASTER_READ_EN to sample spi_miso and capture rd_data;
// without it rd_data stays 8'h00 while read frames and rd_valid behave the same.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high, cs_n high
// SETUP | cs_n low, bit 31 on mosi, sclk low ahead of the first rise
// HIGH  | sclk high (miso sampled on the edge that entered this state)
// LOW   | sclk low, next bit shifted onto mosi
// HOLD  | sclk low after the 32nd rise, cs_n still low
// GAP   | cs_n high, enforces minimum spacing between frames

module spi_cmd_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [16:0] req_addr,
  input  logic [7:0]  req_data,
  input  logic        req_rw_b,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic        rw_q;
  logic        rd_valid_q;
  logic        tmr_tc;
  logic        accept;
  logic        frame_done;
  logic        active;

  assign tmr_tc     = (tmr_q == 8'd0);
  assign accept     = (state_q == IDLE) && req_valid;
  assign frame_done = (state_q == HOLD) && tmr_tc;
  assign active     = (state_q == SETUP) || (state_q == LOW) ||
                      (state_q == HIGH)  || (state_q == HOLD);

  // Outputs decode straight from registered state so reset forces them at once
  assign req_ready = (state_q == IDLE);
  assign spi_cs_n  = !active;
  assign spi_sclk  = (state_q == HIGH);
  assign spi_mosi  = active & tx_q[31];
  assign rd_valid  = rd_valid_q;

  // State, phase timer, remaining-bit counter and transmit shifter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q   <= 8'd0;
      bit_q   <= 5'd0;
      tx_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Next state; the down-counter reloads on every phase change, shift on sclk fall
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    if (state_q != IDLE && !tmr_tc) tmr_d = tmr_q - 8'd1;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          tmr_d   = DIV_LOAD;
          bit_d   = 5'd31;
          tx_d    = {req_rw_b, req_addr[16], 6'b0, req_addr[15:0],
                     req_rw_b ? 8'h00 : req_data};
        end
      end
      SETUP, LOW: begin
        if (tmr_tc) begin
          state_d = HIGH;
          tmr_d   = DIV_LOAD;
        end
      end
      HIGH: begin
        if (tmr_tc) begin
          tmr_d = DIV_LOAD;
          if (bit_q == 5'd0) begin
            state_d = HOLD;
          end else begin
            state_d = LOW;
            bit_d   = bit_q - 5'd1;
            tx_d    = {tx_q[30:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (tmr_tc) begin
          state_d = GAP;
          tmr_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (tmr_tc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch read/write direction at acceptance; pulse rd_valid as a read frame closes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rw_q       <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (accept) rw_q <= req_rw_b;
      rd_valid_q <= frame_done & rw_q;
    end
  end

`ifdef SPI_CMD_MASTER_READ_EN
  logic       sample_miso;
  logic [7:0] rx_q;
  logic [7:0] rd_data_q;

  // miso is taken on the same clk edge that raises sclk
  assign sample_miso = ((state_q == SETUP) || (state_q == LOW)) && tmr_tc;
  assign rd_data     = rd_data_q;

  // Keep the last eight sampled bits; publish them when a read frame closes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q      <= 8'h00;
      rd_data_q <= 8'h00;
    end else begin
      if (sample_miso) rx_q <= {rx_q[6:0], spi_miso};
      if (frame_done && rw_q) rd_data_q <= rx_q;
    end
  end
`else
  logic miso_unused;

  assign miso_unused = spi_miso;
  assign rd_data     = 8'h00;
`endif

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: a CLK_DIV=2 instance and a CLK_DIV=1 instance share the
// request inputs (req_valid steered by sel). A negedge monitor assembles each cs_n-low
// window into an observed-frame record; tasks push expected frames when they issue a
// request and pop/compare both queues when the frame has been seen on the wires.
module tb_spi_cmd_master;
  localparam int CS_GAP = 2;

  typedef struct {
    logic [31:0] bits;
    logic        rdv;
    logic [7:0]  rdd;
  } exp_t;

  typedef struct {
    logic [31:0] bits;
    int          edges;
    int          low;
    int          hi;
    int          span;
    int          gap;
    logic        rdv_at_rise;
    logic [7:0]  rdd;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [16:0] req_addr = '0;
  logic [7:0]  req_data = '0;
  logic        req_rw_b = 1'b0;
  logic        spi_miso = 1'b0;
  logic        sel = 1'b0;

  logic       req_valid0, req_valid1;
  logic       ready0, ready1, rdv0_o, rdv1_o, sclk0, sclk1, cs0, cs1, mosi0, mosi1;
  logic [7:0] rdd0, rdd1;
  logic       m_ready, m_rdv, m_sclk, m_cs, m_mosi;
  logic [7:0] m_rdd;

  assign req_valid0 = req_valid & ~sel;
  assign req_valid1 = req_valid & sel;
  assign m_ready = sel ? ready1 : ready0;
  assign m_rdv   = sel ? rdv1_o : rdv0_o;
  assign m_sclk  = sel ? sclk1  : sclk0;
  assign m_cs    = sel ? cs1    : cs0;
  assign m_mosi  = sel ? mosi1  : mosi0;
  assign m_rdd   = sel ? rdd1   : rdd0;

  spi_cmd_master #(.CLK_DIV(2), .CS_GAP(CS_GAP)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid0), .req_ready(ready0),
    .req_addr(req_addr), .req_data(req_data), .req_rw_b(req_rw_b),
    .rd_data(rdd0), .rd_valid(rdv0_o), .spi_sclk(sclk0), .spi_cs_n(cs0),
    .spi_mosi(mosi0), .spi_miso(spi_miso));

  spi_cmd_master #(.CLK_DIV(1), .CS_GAP(CS_GAP)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid1), .req_ready(ready1),
    .req_addr(req_addr), .req_data(req_data), .req_rw_b(req_rw_b),
    .rd_data(rdd1), .rd_valid(rdv1_o), .spi_sclk(sclk1), .spi_cs_n(cs1),
    .spi_mosi(mosi1), .spi_miso(spi_miso));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  logic [7:0] exp_rd[2];
  logic [7:0] resp_byte = 8'h00;

  // Monitor state
  int          cyc = 0;
  bit          in_frame = 0;
  logic [31:0] cur_bits = '0;
  int          cur_edges = 0, cur_low = 0, cur_hi = 0, cur_gap = 0;
  int          first_rise = 0, last_rise = 0, hi_run = 0;
  int          mosi_glitch = 0, idle_bad = 0, rdv_total = 0;
  logic        prev_sclk = 1'b0, prev_mosi = 1'b0;
  obs_t        mon_o;

  function automatic logic [31:0] make_frame(input logic [16:0] a, input logic [7:0] d,
                                             input logic rw);
    return {rw, a[16], 6'b0, a[15:0], rw ? 8'h00 : d};
  endfunction

  function automatic logic [7:0] rd_model(input logic [7:0] r);
`ifdef SPI_CMD_MASTER_READ_EN
    return r;
`else
    return 8'h00 & r;
`endif
  endfunction

  // Frame monitor and responder, sampled on the falling clk edge
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      in_frame  = 0;
      cur_edges = 0;
      hi_run    = 0;
      prev_sclk = 1'b0;
      prev_mosi = 1'b0;
      spi_miso  = 1'b0;
    end else begin
      if (!m_cs) begin
        if (!in_frame) begin
          in_frame = 1; cur_bits = '0; cur_edges = 0; cur_low = 0; cur_hi = 0;
          cur_gap = hi_run;
        end
        cur_low++;
        if (m_sclk) cur_hi++;
        if (m_sclk && !prev_sclk) begin
          cur_bits = {cur_bits[30:0], m_mosi};
          cur_edges++;
          if (cur_edges == 1) first_rise = cyc;
          last_rise = cyc;
        end
        if (m_sclk && prev_sclk && (m_mosi !== prev_mosi)) mosi_glitch++;
        hi_run = 0;
      end else begin
        if (in_frame) begin
          mon_o.bits = cur_bits; mon_o.edges = cur_edges; mon_o.low = cur_low;
          mon_o.hi = cur_hi; mon_o.span = last_rise - first_rise; mon_o.gap = cur_gap;
          mon_o.rdv_at_rise = m_rdv; mon_o.rdd = m_rdd;
          obs_q.push_back(mon_o);
          in_frame = 0;
        end
        hi_run++;
        if (m_sclk !== 1'b0 || m_mosi !== 1'b0) idle_bad++;
      end
      if (m_rdv === 1'b1) rdv_total++;
      if (in_frame && cur_edges >= 24 && cur_edges <= 31) spi_miso = resp_byte[31 - cur_edges];
      else spi_miso = cur_edges[0];
      prev_sclk = m_sclk;
      prev_mosi = m_mosi;
    end
  end

  // Issue one request on the selected instance and record its expected frame
  task automatic send_req(input logic [16:0] a, input logic [7:0] d, input logic rw,
                          input bit keep, output bit acc);
    exp_t e;
    @(negedge clk);
    req_addr = a; req_data = d; req_rw_b = rw; req_valid = 1'b1; acc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_ready === 1'b1) begin
        @(posedge clk);
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    #1;
    req_valid = keep;
    req_addr  = 17'($urandom);
    req_data  = 8'($urandom);
    req_rw_b  = 1'($urandom);
    if (rw) exp_rd[sel] = rd_model(resp_byte);
    e.bits = make_frame(a, d, rw);
    e.rdv  = rw;
    e.rdd  = exp_rd[sel];
    exp_q.push_back(e);
  endtask

  task automatic get_frame(output obs_t o, output bit got);
    got = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        got = 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready0); end
    n_cmp++; if (cs0 !== 1'b1) begin n_err++; $display("FAIL reset_cs_n: got %b want 1", cs0); end
    n_cmp++; if (sclk0 !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b want 0", sclk0); end
    n_cmp++; if (mosi0 !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", mosi0); end
    n_cmp++; if (rdv0_o !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rdv0_o); end
    n_cmp++; if (rdd0 !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h want 00", rdd0); end
    n_cmp++; if (cs1 !== 1'b1 || ready1 !== 1'b1) begin
      n_err++; $display("FAIL reset_div1: got cs_n=%b ready=%b want 1 1", cs1, ready1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write();
    obs_t o; exp_t e; bit acc, got; int rdv0;
    sel = 1'b0; rdv0 = rdv_total;
    send_req(17'h15581, 8'h7e, 1'b0, 0, acc);
    n_cmp++; if (!acc) begin n_err++; $display("FAIL write_accept: got %0d want 1", acc); end
    n_cmp++; if (m_ready !== 1'b0) begin n_err++; $display("FAIL write_ready_drop: got %b want 0", m_ready); end
    get_frame(o, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL write_frame_timeout: got none want 1 frame"); return; end
    e = exp_q.pop_front();
    n_cmp++; if (o.bits !== e.bits) begin n_err++; $display("FAIL write_mosi: got %h want %h", o.bits, e.bits); end
    n_cmp++; if (o.edges != 32) begin n_err++; $display("FAIL write_edges: got %0d want 32", o.edges); end
    n_cmp++; if (o.low != 130) begin n_err++; $display("FAIL write_cs_low: got %0d want 130", o.low); end
    n_cmp++; if (o.hi != 64) begin n_err++; $display("FAIL write_sclk_high: got %0d want 64", o.hi); end
    n_cmp++; if (o.span != 124) begin n_err++; $display("FAIL write_sclk_span: got %0d want 124", o.span); end
    n_cmp++; if (o.rdv_at_rise !== e.rdv) begin n_err++; $display("FAIL write_rdv_at_rise: got %b want %b", o.rdv_at_rise, e.rdv); end
    n_cmp++; if (o.rdd !== e.rdd) begin n_err++; $display("FAIL write_rd_data: got %h want %h", o.rdd, e.rdd); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rdv_total - rdv0 != 0) begin n_err++; $display("FAIL write_rd_valid: got %0d want 0", rdv_total - rdv0); end
  endtask

  task automatic test_read();
    obs_t o; exp_t e; bit acc, got; int rdv0;
    sel = 1'b0; rdv0 = rdv_total; resp_byte = 8'ha5;
    send_req(17'h000ff, 8'h5a, 1'b1, 0, acc);
    n_cmp++; if (!acc) begin n_err++; $display("FAIL read_accept: got %0d want 1", acc); end
    n_cmp++; if (m_mosi !== 1'b1 || m_sclk !== 1'b0 || m_cs !== 1'b0) begin
      n_err++; $display("FAIL read_first_bit: got mosi=%b sclk=%b cs_n=%b want 1 0 0", m_mosi, m_sclk, m_cs);
    end
    get_frame(o, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL read_frame_timeout: got none want 1 frame"); return; end
    e = exp_q.pop_front();
    n_cmp++; if (o.bits !== e.bits) begin n_err++; $display("FAIL read_mosi: got %h want %h", o.bits, e.bits); end
    n_cmp++; if (o.low != 130) begin n_err++; $display("FAIL read_cs_low: got %0d want 130", o.low); end
    n_cmp++; if (o.rdv_at_rise !== e.rdv) begin n_err++; $display("FAIL read_rdv_at_rise: got %b want %b", o.rdv_at_rise, e.rdv); end
    n_cmp++; if (o.rdd !== e.rdd) begin n_err++; $display("FAIL read_rd_data: got %h want %h", o.rdd, e.rdd); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rdv_total - rdv0 != 1) begin n_err++; $display("FAIL read_rd_valid_cycles: got %0d want 1", rdv_total - rdv0); end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e; bit acc1, acc2, got; int rdv0;
    sel = 1'b0; rdv0 = rdv_total;
    send_req(17'h0a5c3, 8'h19, 1'b0, 1, acc1);
    send_req(17'h1ffff, 8'he6, 1'b0, 0, acc2);
    n_cmp++; if (!(acc1 && acc2)) begin n_err++; $display("FAIL b2b_accept: got %0d%0d want 11", acc1, acc2); end
    for (int k = 0; k < 2; k++) begin
      get_frame(o, got);
      n_cmp++; if (!got) begin n_err++; $display("FAIL b2b_frame_timeout: got none want frame %0d", k); return; end
      e = exp_q.pop_front();
      n_cmp++; if (o.bits !== e.bits) begin n_err++; $display("FAIL b2b_mosi: frame %0d got %h want %h", k, o.bits, e.bits); end
      n_cmp++; if (o.low != 130 || o.edges != 32) begin
        n_err++; $display("FAIL b2b_shape: frame %0d got low=%0d edges=%0d want 130 32", k, o.low, o.edges);
      end
      if (k == 1) begin
        n_cmp++; if (o.gap != CS_GAP + 1) begin n_err++; $display("FAIL b2b_cs_gap: got %0d want %0d", o.gap, CS_GAP + 1); end
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (rdv_total != rdv0) begin n_err++; $display("FAIL b2b_rd_valid: got %0d want 0", rdv_total - rdv0); end
  endtask

  task automatic test_reset_abort();
    obs_t o; exp_t e; bit acc, got; int rdv0;
    sel = 1'b0; resp_byte = 8'hc3;
    send_req(17'h0f0f0, 8'h00, 1'b1, 0, acc);
    exp_q.delete();
    rdv0 = rdv_total;
    got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (cur_edges >= 10) begin got = 1; break; end
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL abort_tenth_edge_timeout: got %0d edges want 10", cur_edges); return; end
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_cmp++; if (cs0 !== 1'b1 || sclk0 !== 1'b0 || mosi0 !== 1'b0) begin
      n_err++; $display("FAIL abort_immediate: got cs_n=%b sclk=%b mosi=%b want 1 0 0", cs0, sclk0, mosi0);
    end
    n_cmp++; if (ready0 !== 1'b1 || rdv0_o !== 1'b0 || rdd0 !== 8'h00) begin
      n_err++; $display("FAIL abort_outputs: got ready=%b rd_valid=%b rd_data=%h want 1 0 00", ready0, rdv0_o, rdd0);
    end
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    req_addr = 17'h03c21; req_data = 8'hb4; req_rw_b = 1'b0; req_valid = 1'b1;
    #9 reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ready0 !== 1'b0 || cs0 !== 1'b0) begin
      n_err++; $display("FAIL abort_first_edge_accept: got ready=%b cs_n=%b want 0 0", ready0, cs0);
    end
    req_valid = 1'b0; req_addr = 17'h1aaaa; req_data = 8'h11; req_rw_b = 1'b1;
    e.bits = make_frame(17'h03c21, 8'hb4, 1'b0); e.rdv = 1'b0; e.rdd = exp_rd[0];
    exp_q.push_back(e);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL abort_stray_frame: got %0d frames want 0", obs_q.size()); end
    get_frame(o, got);
    n_cmp++; if (!got) begin n_err++; $display("FAIL abort_frame_timeout: got none want 1 frame"); return; end
    e = exp_q.pop_front();
    n_cmp++; if (o.bits !== e.bits || o.low != 130) begin
      n_err++; $display("FAIL abort_next_write: got %h/%0d want %h/130", o.bits, o.low, e.bits);
    end
    n_cmp++; if (o.rdd !== e.rdd) begin n_err++; $display("FAIL abort_rd_data: got %h want %h", o.rdd, e.rdd); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rdv_total != rdv0) begin n_err++; $display("FAIL abort_rd_valid: got %0d want 0", rdv_total - rdv0); end
  endtask

  task automatic test_clkdiv1();
    obs_t o; exp_t e; bit acc, got; int rdv0;
    logic [16:0] addrs[2];
    logic [7:0]  datas[2];
    logic        rws[2];
    logic [7:0]  resps[2];
    addrs = '{17'h12345, 17'h10000};
    datas = '{8'ha3, 8'h00};
    rws   = '{1'b0, 1'b1};
    resps = '{8'h00, 8'h3c};
    sel = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rdv0 = rdv_total; resp_byte = resps[k];
      send_req(addrs[k], datas[k], rws[k], 0, acc);
      n_cmp++; if (!acc) begin n_err++; $display("FAIL div1_accept: frame %0d got 0 want 1", k); end
      get_frame(o, got);
      n_cmp++; if (!got) begin n_err++; $display("FAIL div1_frame_timeout: got none want frame %0d", k); return; end
      e = exp_q.pop_front();
      n_cmp++; if (o.bits !== e.bits) begin n_err++; $display("FAIL div1_mosi: frame %0d got %h want %h", k, o.bits, e.bits); end
      n_cmp++; if (o.low != 65 || o.edges != 32) begin
        n_err++; $display("FAIL div1_shape: frame %0d got low=%0d edges=%0d want 65 32", k, o.low, o.edges);
      end
      n_cmp++; if (o.hi != 32 || o.span != 62) begin
        n_err++; $display("FAIL div1_sclk_period: frame %0d got hi=%0d span=%0d want 32 62", k, o.hi, o.span);
      end
      n_cmp++; if (o.rdv_at_rise !== e.rdv || o.rdd !== e.rdd) begin
        n_err++; $display("FAIL div1_read: frame %0d got rdv=%b rdd=%h want %b %h", k, o.rdv_at_rise, o.rdd, e.rdv, e.rdd);
      end
      repeat (3) @(negedge clk);
      n_cmp++; if (rdv_total - rdv0 != int'(rws[k])) begin
        n_err++; $display("FAIL div1_rd_valid_cycles: frame %0d got %0d want %0d", k, rdv_total - rdv0, rws[k]);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_idle_lines();
    n_cmp++; if (idle_bad != 0) begin n_err++; $display("FAIL idle_lines: got %0d bad cycles want 0", idle_bad); end
    n_cmp++; if (mosi_glitch != 0) begin n_err++; $display("FAIL mosi_while_sclk_high: got %0d changes want 0", mosi_glitch); end
    n_cmp++; if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_err++; $display("FAIL leftover_frames: got exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
    end
  endtask

  initial begin
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_abort();
    test_clkdiv1();
    test_idle_lines();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
